// File: rtl/iddr_gearbox_nx.sv
// Multi-lane 1:RATIO input deserializer with per-lane bit-slip and an
// automatic training-pattern search. Everything runs on ECLK; each lane
// marks its own words with a one-cycle QVALID strobe.

// One lane: bit history, word window, phase counter, slip control, align FSM.
module iddr_gearbox_lane #(
  parameter int              RATIO         = 8,
  parameter logic [RATIO-1:0] ALIGN_PATTERN = RATIO'(8'hB4),
  parameter int              SETTLE_WORDS  = 2
) (
  input  logic             ECLK,
  input  logic             RST,
  input  logic             d_rise,
  input  logic             d_fall,
  input  logic             alignwd,
  input  logic             align_en,
  output logic [RATIO-1:0] q,
  output logic             qvalid,
  output logic             locked,
  output logic             align_err
);
  localparam int HALF = RATIO / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = $clog2(RATIO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_LOCK, S_FAIL
  } state_t;

  // hist[RATIO] is the newest bit, hist[0] the oldest
  logic [RATIO:0]   hist;
  logic             sel;
  logic [CW-1:0]    cnt;
  logic [CW:0]      cnt_sum;
  logic [CW-1:0]    cnt_nxt;
  logic [RATIO-1:0] word_r;
  logic [1:0]       vld_pipe;
  logic             aw_r, aw_d;
  state_t           st;
  logic [SW-1:0]    slip_cnt;
  logic [2:0]       settle;

  logic             slip, last, early, strobe;
  logic [RATIO-1:0] win0, win1, cap_word;

  // Window select, slip source and strobe decode
  always_comb begin
    win0     = hist[RATIO:1];
    win1     = hist[RATIO-1:0];
    slip     = align_en ? (st == S_SLIP) : (aw_r & ~aw_d);
    last     = (cnt == CW'(HALF - 1));
    // a 1->0 slip drops one cycle from the period; if that cycle was the
    // last one before the strobe, the strobe is pulled into this cycle
    early    = slip & sel & (cnt == CW'(HALF - 2));
    strobe   = last | early;
    // regular strobe captures with the pre-slip window; the early one
    // already belongs to the new (SEL=0) alignment
    cap_word = (last && sel) ? win1 : win0;
    cnt_sum  = {1'b0, cnt} + ((slip && sel) ? (CW+1)'(2) : (CW+1)'(1));
    cnt_nxt  = (cnt_sum >= (CW+1)'(HALF)) ? CW'(cnt_sum - (CW+1)'(HALF))
                                          : CW'(cnt_sum);
  end

  // Datapath: history shift, slip, phase counter, word capture
  always_ff @(posedge ECLK) begin
    if (RST) begin
      hist     <= '0;
      sel      <= 1'b0;
      cnt      <= '0;
      word_r   <= '0;
      vld_pipe <= '0;
      q        <= '0;
      aw_r     <= 1'b0;
      aw_d     <= 1'b0;
    end else begin
      hist     <= {d_fall, d_rise, hist[RATIO:2]};
      aw_r     <= alignwd;
      aw_d     <= aw_r;
      if (slip) sel <= ~sel;
      cnt      <= cnt_nxt;
      vld_pipe <= {vld_pipe[0], strobe};
      if (strobe)      word_r <= cap_word;
      if (vld_pipe[0]) q      <= word_r;
    end
  end

  assign qvalid = vld_pipe[1];

  // Auto-align search: compare, slip, settle, repeat until lock or RATIO slips
  always_ff @(posedge ECLK) begin
    if (RST) begin
      st        <= S_IDLE;
      slip_cnt  <= '0;
      settle    <= '0;
      locked    <= 1'b0;
      align_err <= 1'b0;
    end else if (!align_en) begin
      st        <= S_IDLE;
      locked    <= 1'b0;
      align_err <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          st       <= S_CHECK;
          slip_cnt <= '0;
        end
        S_CHECK: begin
          if (strobe) begin
            if (cap_word == ALIGN_PATTERN) begin
              st     <= S_LOCK;
              locked <= 1'b1;
            end else if (slip_cnt == SW'(RATIO)) begin
              st        <= S_FAIL;
              align_err <= 1'b1;
            end else begin
              st <= S_SLIP;
            end
          end
        end
        S_SLIP: begin
          slip_cnt <= slip_cnt + SW'(1);
          settle   <= '0;
          st       <= S_WAIT;
        end
        S_WAIT: begin
          if (strobe) begin
            if (settle == 3'(SETTLE_WORDS - 1)) st <= S_CHECK;
            else                                settle <= settle + 3'd1;
          end
        end
        S_LOCK:  st <= S_LOCK;
        S_FAIL:  st <= S_FAIL;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// Top: LANES independent lanes sharing ECLK, RST and ALIGN_EN.
module iddr_gearbox_nx #(
  parameter int               LANES         = 1,
  parameter int               RATIO         = 8,
  parameter logic [RATIO-1:0] ALIGN_PATTERN = RATIO'(8'hB4),
  parameter int               SETTLE_WORDS  = 2
) (
  input  logic                   ECLK,
  input  logic                   RST,
  input  logic [LANES-1:0]       D_RISE,
  input  logic [LANES-1:0]       D_FALL,
  input  logic [LANES-1:0]       ALIGNWD,
  input  logic                   ALIGN_EN,
  output logic [LANES*RATIO-1:0] Q,
  output logic [LANES-1:0]       QVALID,
  output logic [LANES-1:0]       LOCKED,
  output logic [LANES-1:0]       ALIGN_ERR
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    iddr_gearbox_lane #(
      .RATIO        (RATIO),
      .ALIGN_PATTERN(ALIGN_PATTERN),
      .SETTLE_WORDS (SETTLE_WORDS)
    ) u_lane (
      .ECLK     (ECLK),
      .RST      (RST),
      .d_rise   (D_RISE[l]),
      .d_fall   (D_FALL[l]),
      .alignwd  (ALIGNWD[l]),
      .align_en (ALIGN_EN),
      .q        (Q[l*RATIO +: RATIO]),
      .qvalid   (QVALID[l]),
      .locked   (LOCKED[l]),
      .align_err(ALIGN_ERR[l])
    );
  end
endmodule

// File: tb/tb_iddr_gearbox_nx.sv
// Bench for iddr_gearbox_nx: a bit-stream reference model feeds a per-lane
// scoreboard; directed phases cover reset timing, manual slip, auto-align
// lock, search failure and reset during a search.
module tb_iddr_gearbox_nx;
  localparam int LANES = 4;
  localparam int RATIO = 8;
  localparam int P     = RATIO + 1;
  localparam logic [7:0] PAT = 8'hB4;

  logic                   ECLK = 1'b0;
  logic                   RST  = 1'b1;
  logic [LANES-1:0]       D_RISE = '0, D_FALL = '0, ALIGNWD = '0;
  logic                   ALIGN_EN = 1'b0;
  logic [LANES*RATIO-1:0] Q;
  logic [LANES-1:0]       QVALID, LOCKED, ALIGN_ERR;

  int checks = 0;
  int errors = 0;

  iddr_gearbox_nx #(.LANES(LANES), .RATIO(RATIO), .ALIGN_PATTERN(PAT), .SETTLE_WORDS(2)) dut (
    .ECLK(ECLK), .RST(RST), .D_RISE(D_RISE), .D_FALL(D_FALL), .ALIGNWD(ALIGNWD),
    .ALIGN_EN(ALIGN_EN), .Q(Q), .QVALID(QVALID), .LOCKED(LOCKED), .ALIGN_ERR(ALIGN_ERR));

  always #5 ECLK = ~ECLK;

  // stimulus source
  int         mode = 0;        // 0 random bits, 1 repeating pattern
  logic [7:0] src_pat = PAT;
  int         skew[LANES];
  int         pos[LANES];

  function automatic logic [7:0] rot(input logic [7:0] p, input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = p[(b + k) % 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // drive next D pair, then advance one edge
  task automatic step();
    for (int l = 0; l < LANES; l++) begin
      if (mode == 0) begin
        D_RISE[l] = 1'($urandom);
        D_FALL[l] = 1'($urandom);
      end else begin
        D_RISE[l] = src_pat[(pos[l] + skew[l]) % RATIO];
        D_FALL[l] = src_pat[(pos[l] + 1 + skew[l]) % RATIO];
      end
      pos[l] += 2;
    end
    @(posedge ECLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ALIGNWD = '0;
    repeat (3) step();
    RST = 1'b0;
    for (int l = 0; l < LANES; l++) pos[l] = 0;
  endtask

  // reference model: stream of bits per lane, words tiled by end index;
  // every slip makes the next word end one bit earlier
  logic             stream[LANES][$];
  int               wend[LANES];
  logic [RATIO-1:0] exp_q[LANES][$];
  logic             m_awr[LANES], m_awd[LANES];

  always @(posedge ECLK) begin
    logic [RATIO-1:0] w;
    for (int l = 0; l < LANES; l++) begin
      if (RST) begin
        stream[l].delete();
        for (int i = 0; i < P; i++) stream[l].push_back(1'b0);
        wend[l] = P + RATIO - 3;
        exp_q[l].delete();
        m_awr[l] = 1'b0;
        m_awd[l] = 1'b0;
      end else begin
        if (m_awr[l] && !m_awd[l] && !ALIGN_EN) wend[l] = wend[l] - 1;
        m_awd[l] = m_awr[l];
        m_awr[l] = ALIGNWD[l];
        stream[l].push_back(D_RISE[l]);
        stream[l].push_back(D_FALL[l]);
        while (wend[l] <= stream[l].size() - 1) begin
          for (int b = 0; b < RATIO; b++) w[b] = stream[l][wend[l] - RATIO + 1 + b];
          exp_q[l].push_back(w);
          wend[l] = wend[l] + RATIO;
        end
      end
    end
  end

  // monitor: pops expected words on QVALID, tracks lane 0 strobe intervals
  bit sb_en = 0;
  bit iv_en = 0;
  int iv3 = 0, iv4 = 0, ivx = 0, last_v = -1, cyc = 0;

  always @(posedge ECLK) cyc++;

  always @(negedge ECLK) begin
    logic [RATIO-1:0] w;
    if (sb_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (QVALID[l] === 1'b1) begin
          checks++;
          if (exp_q[l].size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected lane=%0d actual=%h required=none", l, Q[l*RATIO +: RATIO]);
          end else begin
            w = exp_q[l].pop_front();
            if (Q[l*RATIO +: RATIO] !== w) begin
              errors++;
              $display("FAIL sb_word lane=%0d actual=%h required=%h at %0t", l, Q[l*RATIO +: RATIO], w, $time);
            end
          end
        end
      end
    end
    if (iv_en && QVALID[0] === 1'b1) begin
      if (last_v >= 0) begin
        if (cyc - last_v == 3) iv3++;
        else if (cyc - last_v == 4) iv4++;
        else ivx++;
      end
      last_v = cyc;
    end
  end

  task automatic drain_check();
    for (int l = 0; l < LANES; l++) chk($sformatf("sb_drain%0d", l), 64'(exp_q[l].size() <= 2), 64'd1);
  endtask

  task automatic wait_lock(input string nm);
    int n = 0;
    while (LOCKED !== 4'hF && n < 400) begin step(); n++; end
    chk(nm, 64'(LOCKED), 64'hF);
    chk({nm, "_err"}, 64'(ALIGN_ERR), 64'h0);
    repeat (6) step();
    for (int l = 0; l < LANES; l++) chk($sformatf("%s_q%0d", nm, l), 64'(Q[l*RATIO +: RATIO]), 64'(PAT));
  endtask

  initial begin
    int n;
    for (int l = 0; l < LANES; l++) begin skew[l] = 0; pos[l] = 0; end

    // 1: reset state and first-strobe timing
    mode = 0;
    RST = 1'b1;
    step();
    sb_en = 1;
    repeat (2) begin
      step();
      chk("rst_q", 64'(Q), 64'h0);
      chk("rst_qvalid", 64'(QVALID), 64'h0);
      chk("rst_locked", 64'(LOCKED), 64'h0);
      chk("rst_err", 64'(ALIGN_ERR), 64'h0);
    end
    RST = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      chk($sformatf("qv_timing_c%0d", c), 64'(QVALID), (c == 5 || c == 9 || c == 13) ? 64'hF : 64'h0);
    end

    // 2: repeating pattern, no slips
    mode = 1; src_pat = PAT;
    do_reset();
    repeat (40) step();
    chk("t2_word", 64'(Q[7:0]), 64'(rot(PAT, 6)));

    // 3: manual slips on lane 0, 8 pulses restore the word
    iv_en = 1; last_v = -1; iv3 = 0; iv4 = 0; ivx = 0;
    for (int i = 0; i < 8; i++) begin
      ALIGNWD[0] = 1'b1;
      step();
      ALIGNWD[0] = 1'b0;
      repeat (11) step();
      chk($sformatf("t3_rot%0d", i), 64'(Q[7:0]), 64'(rot(PAT, (6 - (i + 1) + 16) % 8)));
    end
    repeat (8) step();
    iv_en = 0;
    chk("t3_iv3", 64'(iv3), 64'd4);
    chk("t3_ivx", 64'(ivx), 64'd0);
    drain_check();

    // random data with random slip requests, including held levels
    mode = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 5) == 0) ALIGNWD[l] = ~ALIGNWD[l];
      step();
    end
    ALIGNWD = '0;
    repeat (4) step();
    drain_check();
    sb_en = 0;

    // 4: auto-align on skewed lanes
    mode = 1; src_pat = PAT;
    skew[0] = 0; skew[1] = 3; skew[2] = 5; skew[3] = 7;
    do_reset();
    repeat (10) step();
    ALIGN_EN = 1'b1;
    wait_lock("t4_lock");

    // 5: no match possible -> ALIGN_ERR, cleared by ALIGN_EN=0
    ALIGN_EN = 1'b0;
    src_pat = 8'hAA;
    do_reset();
    repeat (10) step();
    ALIGN_EN = 1'b1;
    n = 0;
    while (ALIGN_ERR !== 4'hF && n < 400) begin step(); n++; end
    chk("t5_err", 64'(ALIGN_ERR), 64'hF);
    chk("t5_locked", 64'(LOCKED), 64'h0);
    ALIGN_EN = 1'b0;
    step();
    chk("t5_err_clr", 64'(ALIGN_ERR), 64'h0);

    // 6: reset in the middle of a search, then lock again
    do_reset();
    ALIGN_EN = 1'b1;
    repeat (30) step();
    RST = 1'b1;
    step();
    chk("t6_q", 64'(Q), 64'h0);
    chk("t6_qvalid", 64'(QVALID), 64'h0);
    chk("t6_locked", 64'(LOCKED), 64'h0);
    chk("t6_err", 64'(ALIGN_ERR), 64'h0);
    src_pat = PAT;
    step();
    RST = 1'b0;
    for (int l = 0; l < LANES; l++) pos[l] = 0;
    wait_lock("t6_lock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iddr_gearbox_nx.md
Name: iddr_gearbox_nx

Overview:
Parametrised multi-lane 1:RATIO input deserializer with word alignment. It is the successor of the fixed 1:4 DDR input gearbox.
- Each lane takes one rise/fall bit pair per ECLK cycle from the IO capture flops and assembles RATIO-bit words.
- Per-lane bit-slip is available either manually through ALIGNWD or through an automatic pattern-search FSM.
- The block sits between the IO DDR capture cells and the fabric link layer. It runs entirely in the ECLK domain, with a per-lane QVALID strobe in place of a separate slow clock.

Parameters:
LANES, 1, number of independent lanes (1..16).
RATIO, 8, bits per output word per lane; even, 4..16.
ALIGN_PATTERN, 8'hB4 (RATIO bits), training word searched by the auto-align FSM; must not be rotationally symmetric.
SETTLE_WORDS, 2, QVALID strobes ignored after each auto slip before the next compare (1..7).

Ports:
ECLK  input  1  sole clock; all state updates on its rising edge.
RST  input  1  synchronous, active-high reset.
D_RISE  input  LANES  rising-edge sample per lane; the older bit of each pair.
D_FALL  input  LANES  falling-edge sample per lane; the newer bit of each pair.
ALIGNWD  input  LANES  manual slip request per lane, rising-edge detected; ignored while ALIGN_EN=1.
ALIGN_EN  input  1  1 = auto-align FSM owns slips on all lanes.
Q  output  LANES*RATIO  lane l word at Q[l*RATIO +: RATIO]; bit 0 is the oldest stream bit.
QVALID  output  LANES  one-cycle strobe per lane; Q of that lane is valid while it is high.
LOCKED  output  LANES  auto-align found ALIGN_PATTERN on that lane.
ALIGN_ERR  output  LANES  sticky flag: RATIO slips made without a match.

Behaviour:
- Reset (RST=1 at an edge):
  - Q, QVALID, LOCKED and ALIGN_ERR go to 0.
  - Lane history, SEL, phase counter CNT and FSM state are cleared.
  - RST has priority over every other input, including mid-slip and mid-search.
- Stream order: D_RISE then D_FALL each cycle, so 2 bits per cycle enter a per-lane history of RATIO+1 bits.
- Word window:
  - SEL=0: the newest RATIO bits.
  - SEL=1: the window one bit older.
- Phase counter:
  - CNT runs 0..RATIO/2-1 and increments every cycle.
  - A strobe occurs when CNT=RATIO/2-1.
  - On a strobe, Q is loaded and QVALID=1 on the following cycle (1-cycle register latency).
  - After reset deassertion, the first QVALID appears RATIO/2+1 cycles later; it contains reset zeros mixed with stream bits.
- Slip: each slip moves the lane's word boundary one bit earlier in the stream.
  - SEL 0->1: window only.
  - SEL 1->0: the current period is shortened by one cycle. CNT advances by 2 (mod RATIO/2), and a strobe also fires if CNT was RATIO/2-2.
  - There is no duplicated or dropped bit beyond the 1-bit shift.
  - After RATIO slips the lane returns to its original alignment.
- Manual slip:
  - ALIGNWD is registered; the edge is detected as sampled-high AND previous-sample-low.
  - The slip is applied at the 2nd ECLK edge after ALIGNWD is first sampled high.
  - A held-high level gives exactly one slip; ALIGNWD must be sampled low for at least 1 cycle before the next slip.
  - A slip coincident with a strobe applies after that strobe's Q capture.
- Auto FSM, per lane, active only while ALIGN_EN=1:
  - IDLE: entered when ALIGN_EN=0; ALIGN_EN=1 -> CHECK with slip count reset to 0.
  - CHECK: on a strobe, word==ALIGN_PATTERN -> LOCKED. Otherwise, if slip count=RATIO -> FAIL; else -> SLIP.
  - SLIP: issue one slip, increment slip count -> WAIT.
  - WAIT: count SETTLE_WORDS strobes -> CHECK.
  - LOCKED: LOCKED=1; no further slips; no re-check.
  - FAIL: ALIGN_ERR=1; no slips.
  - ALIGN_EN falling in any state: -> IDLE, LOCKED=0, ALIGN_ERR=0, current SEL/CNT alignment retained.
- Lanes are fully independent; their QVALID phases may differ.
- X on D propagates into Q only; SEL and CNT never go X after reset.

Test Plan:
1. Reset: RATIO=8, hold RST 3 cycles with random D -> Q=0, QVALID=0, LOCKED=0, ALIGN_ERR=0. First QVALID at cycle 5 after release, then every 4 cycles.
2. Word assembly: repeat 8'hB4 oldest-bit-first on lane 0, no slips -> Q[7:0] constant and equal to a rotation of B4, with QVALID period 4.
3. Manual slip: pulse ALIGNWD[0] 1 cycle, 3 times -> each pulse rotates the word by 1 bit (boundary earlier); the 2nd pulse (SEL 1->0) gives one 3-cycle QVALID interval; 8 pulses restore the original word.
4. Auto-align: LANES=4, lanes skewed 0/3/5/7 bits, stream B4 repeated, ALIGN_EN=1 -> every lane reaches LOCKED=1 with Q lane word = 8'hB4 after at most 8 slips; ALIGN_ERR=0.
5. Fail: stream 8'hAA, ALIGN_EN=1 -> after 8 slips ALIGN_ERR=1, LOCKED=0; ALIGN_EN=0 -> ALIGN_ERR clears next cycle.
6. Reset mid-search: assert RST during WAIT on lane 2 -> all outputs 0 the next cycle; re-run with ALIGN_EN=1 -> locks normally.
